// File: rtl/trap_ctrl_pkg.sv
// Shared constants and state encodings for the machine-mode trap controller.
package trap_ctrl_pkg;

    localparam int unsigned CSR_ADDR_W = 12;

    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIE     = 12'h304;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL   = 12'h343;

    // Interrupt codes double as the matching mie enable bit positions.
    localparam int unsigned IRQ_MEI = 11;
    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_MEPC    = 6'b000010,
        S_MCAUSE  = 6'b000100,
        S_MTVAL   = 6'b001000,
        S_MSTATUS = 6'b010000,
        S_MRET    = 6'b100000
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_EXC  = 2'd1,
        WIN_MRET = 2'd2,
        WIN_INT  = 2'd3
    } win_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-side bundle of the trap controller; master = pipeline, slave = trap_ctrl.
interface trap_ctrl_if #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned N_EXT   = 4,
    parameter int unsigned CAUSE_W = 4
);
    localparam int unsigned EXT_W = (N_EXT > 1) ? $clog2(N_EXT) : 1;

    logic               exc_vld_if,   exc_vld_id,   exc_vld_ex;
    logic [CAUSE_W-1:0] exc_cause_if, exc_cause_id, exc_cause_ex;
    logic [ADDR_W-1:0]  exc_pc_if,    exc_pc_id,    exc_pc_ex;
    logic [XLEN-1:0]    exc_tval_if,  exc_tval_id,  exc_tval_ex;
    logic               mret_i;
    logic [ADDR_W-1:0]  int_pc_i;
    logic               tmr_irq_i, sft_irq_i;
    logic [N_EXT-1:0]   ext_irq_i;
    logic [XLEN-1:0]    csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i;
    logic               trap_taken_o;
    logic [ADDR_W-1:0]  trap_addr_o;
    logic               busy_o;
    logic [EXT_W-1:0]   ext_id_o;
    logic               csr_we_o;
    logic [11:0]        csr_addr_o;
    logic [XLEN-1:0]    csr_wdata_o;

    modport master (
        output exc_vld_if, exc_vld_id, exc_vld_ex,
        output exc_cause_if, exc_cause_id, exc_cause_ex,
        output exc_pc_if, exc_pc_id, exc_pc_ex,
        output exc_tval_if, exc_tval_id, exc_tval_ex,
        output mret_i, int_pc_i, tmr_irq_i, sft_irq_i, ext_irq_i,
        output csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
        input  trap_taken_o, trap_addr_o, busy_o, ext_id_o,
        input  csr_we_o, csr_addr_o, csr_wdata_o
    );

    modport slave (
        input  exc_vld_if, exc_vld_id, exc_vld_ex,
        input  exc_cause_if, exc_cause_id, exc_cause_ex,
        input  exc_pc_if, exc_pc_id, exc_pc_ex,
        input  exc_tval_if, exc_tval_id, exc_tval_ex,
        input  mret_i, int_pc_i, tmr_irq_i, sft_irq_i, ext_irq_i,
        input  csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
        output trap_taken_o, trap_addr_o, busy_o, ext_id_o,
        output csr_we_o, csr_addr_o, csr_wdata_o
    );

endinterface

// File: rtl/trap_arbiter.sv
// Combinational event priority: sync exception (EX > ID > IF), then MRET, then
// enabled interrupts (MEI > MSI > MTI) gated by mstatus.MIE.
module trap_arbiter
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned N_EXT   = 4,
    parameter int unsigned CAUSE_W = 4,
    parameter int unsigned EXT_W   = (N_EXT > 1) ? $clog2(N_EXT) : 1
) (
    input  logic               exc_vld_if_i,
    input  logic               exc_vld_id_i,
    input  logic               exc_vld_ex_i,
    input  logic [CAUSE_W-1:0] exc_cause_if_i,
    input  logic [CAUSE_W-1:0] exc_cause_id_i,
    input  logic [CAUSE_W-1:0] exc_cause_ex_i,
    input  logic [ADDR_W-1:0]  exc_pc_if_i,
    input  logic [ADDR_W-1:0]  exc_pc_id_i,
    input  logic [ADDR_W-1:0]  exc_pc_ex_i,
    input  logic [XLEN-1:0]    exc_tval_if_i,
    input  logic [XLEN-1:0]    exc_tval_id_i,
    input  logic [XLEN-1:0]    exc_tval_ex_i,
    input  logic               mret_i,
    input  logic [ADDR_W-1:0]  int_pc_i,
    input  logic               irq_en_i,
    input  logic               mei_en_i,
    input  logic               msi_en_i,
    input  logic               mti_en_i,
    input  logic               tmr_irq_i,
    input  logic               sft_irq_i,
    input  logic [N_EXT-1:0]   ext_irq_i,
    output win_e               win_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [XLEN-1:0]    tval_o,
    output logic               is_int_o,
    output logic [EXT_W-1:0]   ext_id_o
);

    // Lowest-index asserted external line.
    always_comb begin
        ext_id_o = '0;
        for (int i = int'(N_EXT) - 1; i >= 0; i--) begin
            if (ext_irq_i[i]) ext_id_o = EXT_W'(i);
        end
    end

    always_comb begin
        win_o    = WIN_NONE;
        cause_o  = '0;
        pc_o     = '0;
        tval_o   = '0;
        is_int_o = 1'b0;
        if (exc_vld_ex_i) begin
            win_o = WIN_EXC; cause_o = exc_cause_ex_i; pc_o = exc_pc_ex_i; tval_o = exc_tval_ex_i;
        end else if (exc_vld_id_i) begin
            win_o = WIN_EXC; cause_o = exc_cause_id_i; pc_o = exc_pc_id_i; tval_o = exc_tval_id_i;
        end else if (exc_vld_if_i) begin
            win_o = WIN_EXC; cause_o = exc_cause_if_i; pc_o = exc_pc_if_i; tval_o = exc_tval_if_i;
        end else if (mret_i) begin
            win_o = WIN_MRET;
        end else if (irq_en_i && ((mei_en_i && |ext_irq_i) || (msi_en_i && sft_irq_i)
                                  || (mti_en_i && tmr_irq_i))) begin
            win_o    = WIN_INT;
            is_int_o = 1'b1;
            pc_o     = int_pc_i;
            if (mei_en_i && |ext_irq_i)    cause_o = CAUSE_W'(IRQ_MEI);
            else if (msi_en_i && sft_irq_i) cause_o = CAUSE_W'(IRQ_MSI);
            else                            cause_o = CAUSE_W'(IRQ_MTI);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: redirects fetch and sequences mepc/mcause/(mtval)/mstatus
// over the single CSR write port. Define TRAP_MTVAL_EN to include the mtval write.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned N_EXT   = 4,
    parameter int unsigned CAUSE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    trap_ctrl_if.slave bus
);
    localparam int unsigned EXT_W = (N_EXT > 1) ? $clog2(N_EXT) : 1;

    win_e               arb_win;
    logic [CAUSE_W-1:0] arb_cause;
    logic [ADDR_W-1:0]  arb_pc;
    logic [XLEN-1:0]    arb_tval;
    logic               arb_is_int;
    logic [EXT_W-1:0]   arb_ext_id;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]    mcause_q, mcause_d;
    logic [XLEN-1:0]    tval_q, tval_d;
    logic [XLEN-1:0]    mstatus_q, mstatus_d;
    logic [EXT_W-1:0]   ext_id_q, ext_id_d;
    logic               busy_q, busy_d;
    logic               csr_we_q, csr_we_d;
    logic [11:0]        csr_addr_q, csr_addr_d;
    logic [XLEN-1:0]    csr_wdata_q, csr_wdata_d;
    logic               trap_taken_c;
    logic [ADDR_W-1:0]  trap_addr_c;
    logic [ADDR_W-1:0]  base_c;
    logic [XLEN-1:0]    mst_trap_c, mst_mret_c;
    logic               unused_bits;

    trap_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .N_EXT(N_EXT), .CAUSE_W(CAUSE_W), .EXT_W(EXT_W)) u_arb (
        .exc_vld_if_i  (bus.exc_vld_if),   .exc_vld_id_i  (bus.exc_vld_id),   .exc_vld_ex_i  (bus.exc_vld_ex),
        .exc_cause_if_i(bus.exc_cause_if), .exc_cause_id_i(bus.exc_cause_id), .exc_cause_ex_i(bus.exc_cause_ex),
        .exc_pc_if_i   (bus.exc_pc_if),    .exc_pc_id_i   (bus.exc_pc_id),    .exc_pc_ex_i   (bus.exc_pc_ex),
        .exc_tval_if_i (bus.exc_tval_if),  .exc_tval_id_i (bus.exc_tval_id),  .exc_tval_ex_i (bus.exc_tval_ex),
        .mret_i        (bus.mret_i),
        .int_pc_i      (bus.int_pc_i),
        .irq_en_i      (bus.csr_mstatus_i[MSTATUS_MIE]),
        .mei_en_i      (bus.csr_mie_i[IRQ_MEI]),
        .msi_en_i      (bus.csr_mie_i[IRQ_MSI]),
        .mti_en_i      (bus.csr_mie_i[IRQ_MTI]),
        .tmr_irq_i     (bus.tmr_irq_i),
        .sft_irq_i     (bus.sft_irq_i),
        .ext_irq_i     (bus.ext_irq_i),
        .win_o         (arb_win),
        .cause_o       (arb_cause),
        .pc_o          (arb_pc),
        .tval_o        (arb_tval),
        .is_int_o      (arb_is_int),
        .ext_id_o      (arb_ext_id)
    );

    assign base_c = ADDR_W'({bus.csr_mtvec_i[XLEN-1:2], 2'b00});

    // Next state, event latching and the same-cycle redirect.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mcause_d     = mcause_q;
        tval_d       = tval_q;
        mstatus_d    = mstatus_q;
        ext_id_d     = ext_id_q;
        trap_taken_c = 1'b0;
        trap_addr_c  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (rst_n && arb_win != WIN_NONE) begin
                    trap_taken_c = 1'b1;
                    mstatus_d    = bus.csr_mstatus_i;
                    if (arb_win == WIN_MRET) begin
                        state_d     = S_MRET;
                        trap_addr_c = ADDR_W'(bus.csr_mepc_i);
                    end else begin
                        state_d  = S_MEPC;
                        pc_d     = arb_pc;
                        tval_d   = arb_is_int ? '0 : arb_tval;
                        mcause_d = '0;
                        mcause_d[CAUSE_W-1:0] = arb_cause;
                        mcause_d[XLEN-1]      = arb_is_int;
                        if (arb_is_int && bus.csr_mtvec_i[1:0] == 2'b01)
                            trap_addr_c = base_c + ADDR_W'({arb_cause, 2'b00});
                        else
                            trap_addr_c = base_c;
                        if (arb_is_int && arb_cause == CAUSE_W'(IRQ_MEI))
                            ext_id_d = arb_ext_id;
                    end
                end
            end
            S_MEPC:    state_d = S_MCAUSE;
`ifdef TRAP_MTVAL_EN
            S_MCAUSE:  state_d = S_MTVAL;
`else
            S_MCAUSE:  state_d = S_MSTATUS;
`endif
            S_MTVAL:   state_d = S_MSTATUS;
            S_MSTATUS: state_d = S_IDLE;
            S_MRET:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // mstatus images written on trap entry and on MRET, built from the latched copy.
    always_comb begin
        mst_trap_c = mstatus_d;
        mst_trap_c[MSTATUS_MPIE] = mstatus_d[MSTATUS_MIE];
        mst_trap_c[MSTATUS_MIE]  = 1'b0;
        mst_trap_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mst_mret_c = mstatus_d;
        mst_mret_c[MSTATUS_MIE]  = mstatus_d[MSTATUS_MPIE];
        mst_mret_c[MSTATUS_MPIE] = 1'b1;
        mst_mret_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // CSR port contents for the state being entered, so they register alongside it.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        csr_we_d    = 1'b0;
        csr_addr_d  = '0;
        csr_wdata_d = '0;
        unique case (state_d)
            S_MEPC:    begin csr_we_d = 1'b1; csr_addr_d = CSR_MEPC;    csr_wdata_d = XLEN'(pc_d); end
            S_MCAUSE:  begin csr_we_d = 1'b1; csr_addr_d = CSR_MCAUSE;  csr_wdata_d = mcause_d;    end
`ifdef TRAP_MTVAL_EN
            S_MTVAL:   begin csr_we_d = 1'b1; csr_addr_d = CSR_MTVAL;   csr_wdata_d = tval_d;      end
`endif
            S_MSTATUS: begin csr_we_d = 1'b1; csr_addr_d = CSR_MSTATUS; csr_wdata_d = mst_trap_c;  end
            S_MRET:    begin csr_we_d = 1'b1; csr_addr_d = CSR_MSTATUS; csr_wdata_d = mst_mret_c;  end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            mcause_q    <= '0;
            tval_q      <= '0;
            mstatus_q   <= '0;
            ext_id_q    <= '0;
            busy_q      <= 1'b0;
            csr_we_q    <= 1'b0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mcause_q    <= mcause_d;
            tval_q      <= tval_d;
            mstatus_q   <= mstatus_d;
            ext_id_q    <= ext_id_d;
            busy_q      <= busy_d;
            csr_we_q    <= csr_we_d;
            csr_addr_q  <= csr_addr_d;
            csr_wdata_q <= csr_wdata_d;
        end
    end

    assign bus.trap_taken_o = trap_taken_c;
    assign bus.trap_addr_o  = trap_addr_c;
    assign bus.busy_o       = busy_q;
    assign bus.ext_id_o     = ext_id_q;
    assign bus.csr_we_o     = csr_we_q;
    assign bus.csr_addr_o   = csr_addr_q;
    assign bus.csr_wdata_o  = csr_wdata_q;

    assign unused_bits = ^{bus.csr_mie_i, bus.csr_mepc_i, tval_q};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl; honours TRAP_MTVAL_EN to expect the mtval write.
module tb_trap_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    trap_ctrl_if #(.XLEN(64), .ADDR_W(64), .N_EXT(4), .CAUSE_W(4)) bus ();

    trap_ctrl #(.XLEN(64), .ADDR_W(64), .N_EXT(4), .CAUSE_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        bus.exc_vld_if = 1'b0; bus.exc_vld_id = 1'b0; bus.exc_vld_ex = 1'b0;
        bus.mret_i     = 1'b0;
        bus.tmr_irq_i  = 1'b0; bus.sft_irq_i  = 1'b0; bus.ext_irq_i  = '0;
    endtask

    task automatic check_pulse(input string tag, input logic [63:0] addr);
        check_eq({tag, "_taken"}, 64'(bus.trap_taken_o), 64'd1);
        check_eq({tag, "_addr"},  bus.trap_addr_o, addr);
        check_eq({tag, "_busy0"}, 64'(bus.busy_o), 64'd0);
    endtask

    task automatic check_write(input string tag, input logic [11:0] addr, input logic [63:0] data);
        check_eq({tag, "_busy"},  64'(bus.busy_o), 64'd1);
        check_eq({tag, "_nopls"}, 64'(bus.trap_taken_o), 64'd0);
        check_eq({tag, "_we"},    64'(bus.csr_we_o), 64'd1);
        check_eq({tag, "_caddr"}, 64'(bus.csr_addr_o), 64'(addr));
        check_eq({tag, "_wdata"}, bus.csr_wdata_o, data);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_idle_busy"}, 64'(bus.busy_o), 64'd0);
        check_eq({tag, "_idle_we"},   64'(bus.csr_we_o), 64'd0);
        check_eq({tag, "_idle_pls"},  64'(bus.trap_taken_o), 64'd0);
    endtask

    // Walks T+1.. of a trap; event levels stay up until the last write to show they are ignored.
    task automatic trap_seq(input string tag, input logic [63:0] pc, input logic [63:0] cause,
                            input logic [63:0] tval, input logic [63:0] mst);
        step(); check_write({tag, "_mepc"}, 12'h341, pc);
        bus.csr_mstatus_i = 64'h0;
        step(); check_write({tag, "_mcause"}, 12'h342, cause);
`ifdef TRAP_MTVAL_EN
        step(); check_write({tag, "_mtval"}, 12'h343, tval);
`else
        if (tval != tval) check_eq({tag, "_tval_x"}, tval, 64'h0);
`endif
        step(); check_write({tag, "_mstatus"}, 12'h300, mst);
        clear_events();
        step(); check_idle(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_events();
        bus.exc_cause_if = '0; bus.exc_cause_id = '0; bus.exc_cause_ex = '0;
        bus.exc_pc_if    = '0; bus.exc_pc_id    = '0; bus.exc_pc_ex    = '0;
        bus.exc_tval_if  = '0; bus.exc_tval_id  = '0; bus.exc_tval_ex  = '0;
        bus.int_pc_i     = '0;
        bus.csr_mstatus_i = '0; bus.csr_mie_i = '0; bus.csr_mtvec_i = '0; bus.csr_mepc_i = '0;

        // Reset state
        step(); step();
        check_eq("rst_busy",  64'(bus.busy_o), 64'd0);
        check_eq("rst_we",    64'(bus.csr_we_o), 64'd0);
        check_eq("rst_caddr", 64'(bus.csr_addr_o), 64'd0);
        check_eq("rst_wdata", bus.csr_wdata_o, 64'd0);
        check_eq("rst_extid", 64'(bus.ext_id_o), 64'd0);
        check_eq("rst_taken", 64'(bus.trap_taken_o), 64'd0);
        check_eq("rst_addr",  bus.trap_addr_o, 64'd0);
        rst_n = 1'b1;
        step();

        // ID exception, direct mtvec
        bus.csr_mstatus_i = 64'h88;
        bus.csr_mtvec_i   = 64'h8000_0100;
        bus.exc_vld_id = 1'b1; bus.exc_cause_id = 4'd2;
        bus.exc_pc_id  = 64'h8000_0010; bus.exc_tval_id = 64'hDEAD;
        #1 check_pulse("id_exc", 64'h8000_0100);
        trap_seq("id_exc", 64'h8000_0010, 64'd2, 64'hDEAD, 64'h1880);

        // Timer interrupt, vectored mtvec
        bus.csr_mstatus_i = 64'h8;
        bus.csr_mie_i     = 64'h80;
        bus.csr_mtvec_i   = 64'h8000_0101;
        bus.int_pc_i      = 64'h8000_0200;
        bus.tmr_irq_i     = 1'b1;
        #1 check_pulse("mti", 64'h8000_011C);
        trap_seq("mti", 64'h8000_0200, 64'h8000_0000_0000_0007, 64'h0, 64'h1880);

        // External beats timer; lowest set line selects the index
        bus.csr_mstatus_i = 64'h8;
        bus.csr_mie_i     = 64'h880;
        bus.ext_irq_i     = 4'b0110;
        bus.tmr_irq_i     = 1'b1;
        #1 check_pulse("mei", 64'h8000_012C);
        trap_seq("mei", 64'h8000_0200, 64'h8000_0000_0000_000B, 64'h0, 64'h1880);
        check_eq("mei_extid", 64'(bus.ext_id_o), 64'd1);

        // Software beats timer
        bus.csr_mstatus_i = 64'h8;
        bus.csr_mie_i     = 64'h88;
        bus.sft_irq_i     = 1'b1;
        bus.tmr_irq_i     = 1'b1;
        #1 check_pulse("msi", 64'h8000_010C);
        trap_seq("msi", 64'h8000_0200, 64'h8000_0000_0000_0003, 64'h0, 64'h1880);
        check_eq("msi_extid_hold", 64'(bus.ext_id_o), 64'd1);

        // MRET
        bus.csr_mstatus_i = 64'h1880;
        bus.csr_mepc_i    = 64'h8000_0044;
        bus.mret_i        = 1'b1;
        #1 check_pulse("mret", 64'h8000_0044);
        step();
        check_write("mret_mstatus", 12'h300, 64'h1888);
        clear_events();
        step(); check_idle("mret");

        // IF + EX exception with MRET in the same cycle: EX wins, MRET dropped
        bus.csr_mstatus_i = 64'h88;
        bus.csr_mtvec_i   = 64'h8000_0100;
        bus.exc_vld_if = 1'b1; bus.exc_cause_if = 4'd1; bus.exc_pc_if = 64'h8000_0020;
        bus.exc_tval_if = 64'h11;
        bus.exc_vld_ex = 1'b1; bus.exc_cause_ex = 4'd5; bus.exc_pc_ex = 64'h8000_0030;
        bus.exc_tval_ex = 64'h77;
        bus.mret_i     = 1'b1;
        #1 check_pulse("ex_win", 64'h8000_0100);
        trap_seq("ex_win", 64'h8000_0030, 64'd5, 64'h77, 64'h1880);

        // Pending interrupts with MIE=0 are never taken
        bus.csr_mstatus_i = 64'h0;
        bus.csr_mie_i     = 64'h888;
        bus.tmr_irq_i = 1'b1; bus.sft_irq_i = 1'b1; bus.ext_irq_i = 4'b0001;
        #1 check_eq("mie0_taken", 64'(bus.trap_taken_o), 64'd0);
        step(); check_idle("mie0");
        clear_events();

        // Reset during S_MCAUSE abandons the sequence
        bus.csr_mstatus_i = 64'h88;
        bus.exc_vld_id = 1'b1; bus.exc_cause_id = 4'd2; bus.exc_pc_id = 64'h8000_0010;
        #1 check_pulse("rst_mid", 64'h8000_0100);
        step(); check_write("rst_mid_mepc", 12'h341, 64'h8000_0010);
        clear_events();
        step(); check_write("rst_mid_mcause", 12'h342, 64'd2);
        rst_n = 1'b0;
        step(); check_idle("rst_mid");
        check_eq("rst_mid_extid", 64'(bus.ext_id_o), 64'd0);
        rst_n = 1'b1;
        step(); check_idle("rst_mid_after");
        step(); check_idle("rst_mid_after2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Parametrised machine-mode trap controller, successor to the single-channel interrupt/CSR sequencer in the pipeline. It does the following:
- Arbitrates synchronous exceptions from IF/ID/EX, MRET, and prioritised timer/software/N-line external interrupts.
- Redirects fetch to a direct or vectored mtvec target.
- Sequences the mepc/mcause/(mtval)/mstatus writes over the single CSR write port.
It sits beside ctrl and csr_reg.

Parameters:
XLEN, 64, CSR/data width
ADDR_W, 64, instruction address width
N_EXT, 4, external interrupt lines (ORed into MEIP, index latched)
CAUSE_W, 4, exception-code width inside mcause

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
exc_vld_if/id/ex  in  1 each  synchronous exception from stage
exc_cause_if/id/ex  in  CAUSE_W each  exception code
exc_pc_if/id/ex  in  ADDR_W each  faulting instruction PC
exc_tval_if/id/ex  in  XLEN each  trap value
mret_i  in  1  MRET decoded in ID
int_pc_i  in  ADDR_W  PC to resume after an interrupt (oldest un-retired instr)
tmr_irq_i, sft_irq_i  in  1 each  machine timer / software interrupt
ext_irq_i  in  N_EXT  external lines, level
csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i  in  XLEN each  current CSR values
trap_taken_o  out  1  one-cycle redirect pulse
trap_addr_o  out  ADDR_W  redirect target, valid with trap_taken_o
busy_o  out  1  FSM not idle; ctrl holds pipeline
ext_id_o  out  $clog2(N_EXT)  latched index of serviced external line
csr_we_o  out  1  CSR write enable
csr_addr_o  out  12  CSR address
csr_wdata_o  out  XLEN  CSR write data

Behaviour:
- Reset (synchronous, clk rising): FSM to S_IDLE. The following are 0 from the next cycle: trap_taken_o, trap_addr_o, busy_o, ext_id_o, csr_we_o, csr_addr_o, csr_wdata_o. Reset mid-sequence abandons remaining writes.
- Event priority, evaluated only in S_IDLE:
  1. Sync exception: EX > ID > IF.
  2. MRET.
  3. Interrupt, only if mstatus.MIE (bit 3): MEI (mie[11]) > MSI (mie[3]) > MTI (mie[7]).
- Lowest-index set ext line gives ext_id.
- Same-cycle exception and mret_i: the exception wins and MRET is dropped.
- Events while busy_o=1 are ignored; levels re-evaluate on return to S_IDLE.
- Trigger cycle T, combinational in S_IDLE: trap_taken_o=1 and trap_addr_o driven.
  - Latch: pc, cause, tval, is_int, is_mret, and a copy of csr_mstatus_i.
  - Latched pc is the exc_pc of the winning stage, or int_pc_i for an interrupt.
- Latched mcause: {is_int, zeros, code}. Interrupt codes are 11/3/7.
- Target address:
  - MRET: csr_mepc_i.
  - Otherwise base = {mtvec[XLEN-1:2], 2'b00}.
  - Vectored: mtvec[1:0]==2'b01 and an interrupt gives base + 4*code.
  - Modes 2/3 are treated as direct.
- Trap FSM path: S_IDLE -> S_MEPC -> S_MCAUSE -> [S_MTVAL] -> S_MSTATUS -> S_IDLE.
- MRET FSM path: S_IDLE -> S_MRET -> S_IDLE.
- CSR outputs are registered, valid in the cycle the FSM occupies the state:
  - S_MEPC, T+1: 0x341 <= latched pc.
  - S_MCAUSE: 0x342 <= latched mcause.
  - S_MTVAL: 0x343 <= tval.
  - S_MSTATUS: 0x300 <= copy with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11.
  - S_MRET, T+1: 0x300 <= MIE=MPIE, MPIE=1, MPP=2'b11.
- All other bits of the mstatus copy are preserved. csr_we_o=0 in S_IDLE.
- busy_o=1 in every state except S_IDLE. The trap_taken_o pulse is never repeated during a sequence.
- The mip view is not written. Pending interrupts with MIE=0 are never taken.

Optional Feature:
TRAP_MTVAL_EN:
- Defined: S_MTVAL is present and the trap sequence is 4 writes (T+1..T+4).
- Undefined: S_MTVAL is omitted, the sequence is 3 writes (mepc, mcause, mstatus), and exc_tval_* are ignored.

Decomposition:
- Shared defines/package: CSR addresses (0x300, 0x304, 0x305, 0x341, 0x342, 0x343), interrupt codes, mstatus bit positions, one-hot FSM state encodings.
- Sub-module trap_arbiter: combinational priority select producing winner, cause, pc, tval, is_int, ext_id.
- The FSM and registers stay in trap_ctrl.

Test Plan:
- ID exc cause=2, pc=0x8000_0010, mtvec=0x8000_0100: pulse, addr 0x8000_0100; T+1 mepc=0x8000_0010, T+2 mcause=2, last write mstatus 0x88 -> 0x1880.
- MIE=1, mie[7]=1, tmr_irq_i, mtvec=0x8000_0101: addr 0x8000_011C; mcause=0x8000_0000_0000_0007.
- ext_irq_i=4'b0110 with tmr: MEI wins, ext_id_o=1, mcause code 11.
- mret_i, mepc=0x8000_0044, mstatus=0x1880: addr 0x8000_0044; T+1 mstatus=0x1888; busy_o high for exactly 1 cycle.
- Same cycle: IF, EX exc and mret_i: EX cause and pc used; no MRET write. Interrupt with MIE=0: no pulse.
- rst_n low during S_MCAUSE: next cycle csr_we_o=0, busy_o=0; no further writes.
